// File: rtl/hs_mem_pkg.sv
// rtl/hs_mem_pkg.sv - shared widths, response record and FSM states for hs_mem_responder
package hs_mem_pkg;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_RSP_DEPTH = 2;

  // One queued response: request type, echoed address, read or written data
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] rdata;
  } rsp_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/hs_mem_rsp_fifo.sv
// rtl/hs_mem_rsp_fifo.sv - small response FIFO with wrap-around pointers and occupancy count
module hs_mem_rsp_fifo
  import hs_mem_pkg::*;
#(
  parameter int DEPTH = DEF_RSP_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  rsp_t                         push_data,
  input  logic                         pop,
  output rsp_t                         head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_t             entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths also work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Overflow and underflow are refused locally as a safety net
  assign push_ok = push && (count != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = entries[rd_ptr];

  // Entry storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push_ok) begin
      entries[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hs_mem_responder.sv
// rtl/hs_mem_responder.sv - handshaked read/write responder over a self-clearing storage array
module hs_mem_responder
  import hs_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] sweep;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count;
  logic              accept;
  logic              pop;
  rsp_t              push_data;
  rsp_t              head;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Leave INIT on the edge that clears the last address
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (sweep == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Ready comes only from registered state so it never loops back through rsp_ready
  always_comb begin
    req_ready = (state == RUN) && (count < CNT_W'(RSP_DEPTH));
    init_done = (state == RUN);
  end

  assign accept    = req_valid && req_ready;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Reads capture the array before this edge's write; writes echo their own data
  assign push_data = '{write: req_write,
                       addr:  req_addr,
                       rdata: req_write ? req_wdata : mem[req_addr]};

  // Clear-sweep address, one word per INIT cycle
  always_ff @(posedge clk) begin
    if (rst)                sweep <= '0;
    else if (state == INIT) sweep <= sweep + ADDR_W'(1);
  end

  // Storage array: zero fill during INIT, accepted writes during RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)            mem[sweep]    <= '0;
      else if (accept && req_write) mem[req_addr] <= req_wdata;
    end
  end

  hs_mem_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // Stale FIFO slots are masked so the response bus reads zero when empty
  assign rsp_write = rsp_valid ? head.write : 1'b0;
  assign rsp_addr  = rsp_valid ? head.addr  : '0;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;

endmodule

// File: tb/tb_hs_mem_responder.sv
// tb/tb_hs_mem_responder.sv - self-checking bench for hs_mem_responder against a queue/array model
module tb_hs_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [4:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       init_done;

  always #5 clk = ~clk;

  hs_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_addr (rsp_addr),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done)
  );

  typedef struct {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mmem [32];
  int         init_left;
  bit         chk;
  bit         just_reset;
  int         vectors;
  int         errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic w, input logic [4:0] a,
                       input logic [7:0] d, input logic rr, output bit acc);
    bit   exp_ready;
    exp_t e;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    #1;
    exp_ready = (init_left == 0) && (q.size() < 2);
    if (chk) begin
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("init_done", 32'(init_done), 32'(init_left == 0));
      check("rsp_valid", 32'(rsp_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("rsp_write", 32'(rsp_write), 32'(q[0].w));
        check("rsp_addr",  32'(rsp_addr),  32'(q[0].a));
        check("rsp_rdata", 32'(rsp_rdata), 32'(q[0].d));
      end else if (just_reset) begin
        check("rst_rsp_write", 32'(rsp_write), 32'd0);
        check("rst_rsp_addr",  32'(rsp_addr),  32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      end
    end
    @(posedge clk);
    acc = v && exp_ready && !r;
    if (r) begin
      q.delete();
      init_left  = 32;
      just_reset = 1'b1;
      for (int i = 0; i < 32; i++) mmem[i] = 8'h00;
    end else begin
      just_reset = 1'b0;
      if (q.size() != 0 && rr) void'(q.pop_front());
      if (acc) begin
        e.w = w;
        e.a = a;
        e.d = w ? d : mmem[a];
        if (w) mmem[a] = d;
        q.push_back(e);
      end
      if (init_left > 0) init_left--;
    end
    chk = 1'b1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, acc);
  endtask

  initial begin
    bit         acc;
    int         sent;
    logic [4:0] bp_addr [3];

    vectors    = 0;
    errors     = 0;
    chk        = 1'b0;
    just_reset = 1'b0;
    init_left  = 32;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;

    // Reset, then the full clear sweep
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, acc);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, acc);
    idle(34);

    // Every address reads zero after the sweep
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 5'(i), 8'($urandom), 1'b1, acc);
    idle(3);

    // mem[i] = i, then read back
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b1, 5'(i), 8'(i), 1'b1, acc);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 5'(i), 8'($urandom), 1'b1, acc);
    idle(3);

    // Read immediately after write to the same address
    cycle(1'b0, 1'b1, 1'b1, 5'd7, 8'hA5, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 5'd7, 8'h00, 1'b1, acc);
    idle(3);

    // Back-pressure: consumer stalls, three reads offered, only two fit
    bp_addr[0] = 5'd3;
    bp_addr[1] = 5'd7;
    bp_addr[2] = 5'd30;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      if (sent < 3) cycle(1'b0, 1'b1, 1'b0, bp_addr[sent], 8'd0, c >= 5, acc);
      else          cycle(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, c >= 5, acc);
      if (acc) sent++;
    end
    check("bp_sent", 32'(sent), 32'd3);
    idle(3);

    // Reset with two responses pending discards them and re-clears the array
    cycle(1'b0, 1'b1, 1'b1, 5'd31, 8'hFF, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b1, 5'd5,  8'h3C, 1'b0, acc);
    cycle(1'b1, 1'b1, 1'b1, 5'd9,  8'h11, 1'b0, acc);
    idle(33);
    cycle(1'b0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, acc);
    idle(2);

    // Boundary addresses with extreme data, both ways round
    cycle(1'b0, 1'b1, 1'b1, 5'd0,  8'hFF, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b1, 5'd31, 8'h00, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 5'd0,  8'h00, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b1, 5'd0,  8'h00, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b1, 5'd31, 8'hFF, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 5'd0,  8'h00, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 5'd31, 8'h00, 1'b1, acc);
    idle(3);

    // Random traffic with random consumer stalls
    for (int i = 0; i < 400; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 5'($urandom),
            8'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
